line_buffer_3row: RTL and testbench
===================================

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter: LINE_W, default 640, pixels per line (≥4).
REQ-002 Parameter: DW, default 8, pixel width in bits.
REQ-003 Parameter: CW, default 10, column/row counter width; 2**CW SHALL be ≥ LINE_W.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pix_valid_i  input  1  input pixel strobe; one pixel accepted per cycle when high.
REQ-007 sof_i  input  1  start of frame; meaningful only when pix_valid_i=1; marks row 0, column 0.
REQ-008 pix_i  input  DW  raster-order pixel.
REQ-009 valid_o  output  1  a 3-row column is present on d1_o..d3_o.
REQ-010 d1_o  output  DW  pixel two lines above the current one (oldest row).
REQ-011 d2_o  output  DW  pixel one line above the current one.
REQ-012 d3_o  output  DW  current-line pixel.
REQ-013 col_o  output  CW  column index of the column on the outputs.
REQ-014 eol_o  output  1  high with valid_o when col_o = LINE_W-1.
REQ-015 sol_o  output  1  high with valid_o when col_o = 0.

Function
REQ-016 The block SHALL hold two line memories, LM0 (previous line) and LM1 (line before that), each LINE_W x DW.
REQ-017 On an accepted pixel at column c: read LM0[c] and LM1[c] first, then write LM0[c]<=pix_i and LM1[c]<=old LM0[c] (read-before-write in the same cycle).
REQ-018 Outputs SHALL be registered: d3_o=pix_i, d2_o=old LM0[c], d1_o=old LM1[c], col_o=c; latency exactly 1 cycle from the accepted pixel.
REQ-019 Column counter: increments per accepted pixel; wraps LINE_W-1 -> 0 and increments the row state on the wrap.
REQ-020 FSM states: IDLE, FILL0, FILL1, STREAM.
REQ-021 IDLE: pixels without sof_i ignored (memories untouched, no outputs); pix_valid_i&sof_i -> accept as column 0, go to FILL0.
REQ-022 FILL0 -> FILL1 on the wrap of row 0; FILL1 -> STREAM on the wrap of row 1; STREAM remains STREAM on every wrap.
REQ-023 valid_o SHALL be high for exactly one cycle per pixel accepted in STREAM; it SHALL be low for all pixels of FILL0/FILL1.
REQ-024 pix_valid_i low: counters, FSM, and memories hold; valid_o, sol_o, and eol_o go low the next cycle; d*_o/col_o hold their last values.
REQ-025 sof_i with pix_valid_i in any state (including mid-line): abort the frame, pixel becomes column 0 of row 0, FSM -> FILL0; stale memory content is never presented with valid_o high.
REQ-026 No backpressure: the downstream stage SHALL accept every valid_o column.
REQ-027 Downstream median stage consumes d1_o/d2_o/d3_o directly; vertical alignment SHALL be exact (same column c of three consecutive lines).
REQ-028 No frame-height knowledge: the frame ends only by the next sof_i or reset.

Reset
REQ-029 rst_n low SHALL force immediately: FSM=IDLE, column counter=0, valid_o=0, sol_o=0, eol_o=0, d1_o=d2_o=d3_o=0, col_o=0.
REQ-030 Line memory contents are not reset; REQ-023/REQ-025 gating guarantees no stale data is flagged valid.
REQ-031 Reset asserted mid-line SHALL discard the partial frame; after release, the block waits in IDLE for sof_i.

Verification (LINE_W=4, DW=8, pixel = row*16+col)
REQ-032 Continuous frame of 4 lines from sof_i -> valid_o low for the first 8 pixels; row 2, col 1 output: d1=0x01, d2=0x11, d3=0x21, col_o=1; 8 valid_o pulses total.
REQ-033 Same frame with pix_valid_i low every other cycle -> identical output sequence, valid_o only the cycle after each accepted pixel.
REQ-034 Row 2, col 3 -> eol_o=1, d1=0x03, d2=0x13, d3=0x23; row 3, col 0 -> sol_o=1, d1=0x10, d2=0x20, d3=0x30.
REQ-035 sof_i at row 2, col 2 -> no valid_o until the new frame's row 2; first valid column is d1=0x00, d2=0x10, d3=0x20.
REQ-036 Pixels before any sof_i after reset -> valid_o stays 0; rst_n pulse mid-row 2 -> all outputs 0 immediately, FSM IDLE.
REQ-037 Checker: for every valid_o, d1_o/d2_o/d3_o equal the reference model's column col_o of lines r-2/r-1/r.

Source files
------------

// File: rtl/line_buffer_3row.sv
// line_buffer_3row
// Three-row vertical window generator. Two line memories hold the previous
// line (LM0) and the line before it (LM1); every accepted pixel produces a
// registered column {oldest, previous, current} one cycle later. Columns are
// flagged valid only once two full lines of the current frame are stored.

module line_buffer_3row #(
  parameter int LINE_W = 640,
  parameter int DW     = 8,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_valid_i,
  input  logic          sof_i,
  input  logic [DW-1:0] pix_i,
  output logic          valid_o,
  output logic [DW-1:0] d1_o,
  output logic [DW-1:0] d2_o,
  output logic [DW-1:0] d3_o,
  output logic [CW-1:0] col_o,
  output logic          eol_o,
  output logic          sol_o
);

  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL0  = 2'd1,
    ST_FILL1  = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col_nxt;
  logic [CW-1:0] w_col_cur;
  logic          w_acc;
  logic          w_wrap;
  logic          w_valid_nxt;
  logic          w_sol_nxt;
  logic          w_eol_nxt;

  // Line memories: contents are never reset; the valid gating keeps stale
  // data from ever being flagged.
  logic [DW-1:0] r_lm0 [LINE_W];
  logic [DW-1:0] r_lm1 [LINE_W];
  logic [DW-1:0] w_lm0_rd;
  logic [DW-1:0] w_lm1_rd;

  // Decide whether this pixel is taken and which column it lands in; a sof
  // always restarts at column 0 regardless of the current position.
  always_comb begin
    w_acc     = 1'b0;
    w_col_cur = r_col;
    if (pix_valid_i && sof_i) begin
      w_acc     = 1'b1;
      w_col_cur = {CW{1'b0}};
    end else if (pix_valid_i && (r_state != ST_IDLE)) begin
      w_acc     = 1'b1;
      w_col_cur = r_col;
    end else begin
      w_acc     = 1'b0;
      w_col_cur = r_col;
    end
    w_wrap = w_acc && (w_col_cur == LAST_COL);
  end

  // Read-before-write: old contents of column c feed the output column.
  assign w_lm0_rd = r_lm0[w_col_cur];
  assign w_lm1_rd = r_lm1[w_col_cur];

  // Next-state logic: sof restarts the frame, line wraps advance the fill.
  always_comb begin
    w_state_nxt = r_state;
    if (pix_valid_i && sof_i) begin
      w_state_nxt = ST_FILL0;
    end else if (w_wrap) begin
      case (r_state)
        ST_FILL0:  w_state_nxt = ST_FILL1;
        ST_FILL1:  w_state_nxt = ST_STREAM;
        ST_STREAM: w_state_nxt = ST_STREAM;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Column counter advance with wrap at the end of a line.
  always_comb begin
    w_col_nxt = r_col;
    if (!w_acc) begin
      w_col_nxt = r_col;
    end else if (w_wrap) begin
      w_col_nxt = {CW{1'b0}};
    end else begin
      w_col_nxt = w_col_cur + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Output flags: only pixels accepted while streaming (and not restarting
  // the frame) carry three rows of the same frame.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_sol_nxt   = 1'b0;
    w_eol_nxt   = 1'b0;
    if (w_acc && !sof_i && (r_state == ST_STREAM)) begin
      w_valid_nxt = 1'b1;
      w_sol_nxt   = (w_col_cur == {CW{1'b0}});
      w_eol_nxt   = (w_col_cur == LAST_COL);
    end else begin
      w_valid_nxt = 1'b0;
      w_sol_nxt   = 1'b0;
      w_eol_nxt   = 1'b0;
    end
  end

  // State and column registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_col   <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Line memory update: current pixel into LM0, old LM0 shifts into LM1.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lm0[w_col_cur] <= pix_i;
      r_lm1[w_col_cur] <= w_lm0_rd;
    end
  end

  // Registered output column; data and column hold while no pixel arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      sol_o   <= 1'b0;
      eol_o   <= 1'b0;
      d1_o    <= {DW{1'b0}};
      d2_o    <= {DW{1'b0}};
      d3_o    <= {DW{1'b0}};
      col_o   <= {CW{1'b0}};
    end else begin
      valid_o <= w_valid_nxt;
      sol_o   <= w_sol_nxt;
      eol_o   <= w_eol_nxt;
      if (w_acc) begin
        d1_o  <= w_lm1_rd;
        d2_o  <= w_lm0_rd;
        d3_o  <= pix_i;
        col_o <= w_col_cur;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed testbench for line_buffer_3row with LINE_W=4, DW=8, CW=2.
// Pixel value of a frame is base + row*16 + col.

module tb_line_buffer_3row;

  localparam int LINE_W = 4;
  localparam int DW     = 8;
  localparam int CW     = 2;

  logic          clk;
  logic          rst_n;
  logic          pix_valid_i;
  logic          sof_i;
  logic [DW-1:0] pix_i;
  logic          valid_o;
  logic [DW-1:0] d1_o;
  logic [DW-1:0] d2_o;
  logic [DW-1:0] d3_o;
  logic [CW-1:0] col_o;
  logic          eol_o;
  logic          sol_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_vld = 0;

  line_buffer_3row #(.LINE_W(LINE_W), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid_i (pix_valid_i),
    .sof_i       (sof_i),
    .pix_i       (pix_i),
    .valid_o     (valid_o),
    .d1_o        (d1_o),
    .d2_o        (d2_o),
    .d3_o        (d3_o),
    .col_o       (col_o),
    .eol_o       (eol_o),
    .sol_o       (sol_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs at a falling edge; return at the next falling edge when the
  // registered result of this cycle is visible.
  task automatic step(input logic v, input logic s, input logic [7:0] p);
    pix_valid_i = v;
    sof_i       = s;
    pix_i       = p;
    @(negedge clk);
  endtask

  // Send pixel (r,c) of a frame and check the column it produces.
  task automatic px(input int r, input int c, input logic s, input logic [7:0] base);
    logic [7:0] p;
    p = base + 8'(r * 16 + c);
    step(1'b1, s, p);
    if (valid_o === 1'b1) n_vld++;
    chk("valid", 32'(valid_o), 32'(r >= 2));
    if (r >= 2) begin
      chk("d1", 32'(d1_o), 32'(base + 8'((r - 2) * 16 + c)));
      chk("d2", 32'(d2_o), 32'(base + 8'((r - 1) * 16 + c)));
      chk("d3", 32'(d3_o), 32'(p));
      chk("col", 32'(col_o), 32'(c));
      chk("sol", 32'(sol_o), 32'(c == 0));
      chk("eol", 32'(eol_o), 32'(c == LINE_W - 1));
    end else begin
      chk("sol_fill", 32'(sol_o), 32'd0);
      chk("eol_fill", 32'(eol_o), 32'd0);
    end
  endtask

  // Idle cycle (with junk sof/pix) after pixel (r,c): flags drop, data holds.
  task automatic gap(input int r, input int c, input logic [7:0] base);
    step(1'b0, 1'b1, 8'hEE);
    chk("gap_valid", 32'(valid_o), 32'd0);
    chk("gap_sol", 32'(sol_o), 32'd0);
    chk("gap_eol", 32'(eol_o), 32'd0);
    chk("gap_d3", 32'(d3_o), 32'(base + 8'(r * 16 + c)));
    chk("gap_col", 32'(col_o), 32'(c));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_sol"}, 32'(sol_o), 32'd0);
    chk({tag, "_eol"}, 32'(eol_o), 32'd0);
    chk({tag, "_d1"}, 32'(d1_o), 32'd0);
    chk({tag, "_d2"}, 32'(d2_o), 32'd0);
    chk({tag, "_d3"}, 32'(d3_o), 32'd0);
    chk({tag, "_col"}, 32'(col_o), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
    pix_i       = 8'h00;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Pixels before any sof are ignored.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'hAA);
      chk("pre_sof_valid", 32'(valid_o), 32'd0);
      chk("pre_sof_d3", 32'(d3_o), 32'd0);
    end

    // Continuous 4-line frame.
    n_vld = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        px(r, c, (r == 0 && c == 0), 8'h00);
        if (r == 2 && c == 1) begin
          chk("r2c1_d1", 32'(d1_o), 32'h01);
          chk("r2c1_d2", 32'(d2_o), 32'h11);
          chk("r2c1_d3", 32'(d3_o), 32'h21);
        end
        if (r == 2 && c == 3) begin
          chk("r2c3_eol", 32'(eol_o), 32'd1);
          chk("r2c3_d1", 32'(d1_o), 32'h03);
        end
        if (r == 3 && c == 0) begin
          chk("r3c0_sol", 32'(sol_o), 32'd1);
          chk("r3c0_d1", 32'(d1_o), 32'h10);
          chk("r3c0_d3", 32'(d3_o), 32'h30);
        end
      end
    end
    chk("frameA_pulses", 32'(n_vld), 32'd8);
    gap(3, 3, 8'h00);

    // Same frame with a bubble after every pixel.
    n_vld = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        px(r, c, (r == 0 && c == 0), 8'h00);
        gap(r, c, 8'h00);
      end
    end
    chk("frameB_pulses", 32'(n_vld), 32'd8);

    // Frame aborted by sof at row 2, col 2; new frame must refill first.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        px(r, c, (r == 0 && c == 0), 8'h80);
      end
    end
    px(2, 0, 1'b0, 8'h80);
    px(2, 1, 1'b0, 8'h80);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        px(r, c, (r == 0 && c == 0), 8'h00);
        if (r == 2 && c == 0) begin
          chk("abort_first_d1", 32'(d1_o), 32'h00);
          chk("abort_first_d2", 32'(d2_o), 32'h10);
          chk("abort_first_d3", 32'(d3_o), 32'h20);
        end
      end
    end

    // Reset pulse mid-row 2 clears outputs at once and returns to IDLE.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        px(r, c, (r == 0 && c == 0), 8'h40);
      end
    end
    px(2, 0, 1'b0, 8'h40);
    px(2, 1, 1'b0, 8'h40);
    pix_valid_i = 1'b0;
    rst_n       = 1'b0;
    #1;
    all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'h55);
      chk("post_rst_valid", 32'(valid_o), 32'd0);
      chk("post_rst_d3", 32'(d3_o), 32'd0);
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        px(r, c, (r == 0 && c == 0), 8'h00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
